// File: rtl/mem_arbiter_if.sv
// Bus bundle between CPU datapath, loader/debug port, synchronous memory and the arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface mem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        ld_req;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_gnt;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] perf_stall_cnt;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall, ld_gnt, ld_rvalid, ld_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, perf_stall_cnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ld_req, ld_we, ld_addr, ld_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall, ld_gnt, ld_rvalid, ld_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, perf_stall_cnt
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (CPU / loader) arbiter in front of a single-port synchronous memory.
// Define ARB_PERF_EN to build the saturating CPU stall-cycle counter on perf_stall_cnt.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input logic         clk,
    input logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int unsigned WAIT_W = 4;

    typedef enum logic [1:0] {IDLE, CPU_RD, LD_RD} state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   ld_wait_q, ld_wait_d;
    logic [31:0]         cpu_rdata_q, cpu_rdata_d;
    logic [31:0]         ld_rdata_q, ld_rdata_d;
    logic                cpu_win_c, ld_win_c;
    logic                ld_gnt_c, cpu_stall_c;
    logic                mem_en_c, mem_we_c;
    logic [31:0]         mem_addr_c, mem_wdata_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ld_wait_q   <= '0;
            cpu_rdata_q <= '0;
            ld_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            ld_wait_q   <= ld_wait_d;
            cpu_rdata_q <= cpu_rdata_d;
            ld_rdata_q  <= ld_rdata_d;
        end
    end

    // Grant, memory drive and read-data capture; grants only happen in IDLE.
    always_comb begin
        state_d     = state_q;
        cpu_rdata_d = cpu_rdata_q;
        ld_rdata_d  = ld_rdata_q;
        cpu_win_c   = 1'b0;
        ld_win_c    = 1'b0;
        ld_gnt_c    = 1'b0;
        mem_en_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        case (state_q)
            IDLE: begin
                ld_win_c  = bus.ld_req && (!bus.cpu_req || (ld_wait_q == WAIT_W'(STARVE_MAX)));
                cpu_win_c = bus.cpu_req && !ld_win_c;
                if (ld_win_c) begin
                    ld_gnt_c    = 1'b1;
                    mem_en_c    = 1'b1;
                    mem_we_c    = bus.ld_we;
                    mem_addr_c  = bus.ld_addr;
                    mem_wdata_c = bus.ld_wdata;
                    if (!bus.ld_we) state_d = LD_RD;
                end else if (cpu_win_c) begin
                    mem_en_c    = 1'b1;
                    mem_we_c    = bus.cpu_we;
                    mem_addr_c  = bus.cpu_addr;
                    mem_wdata_c = bus.cpu_wdata;
                    if (!bus.cpu_we) state_d = CPU_RD;
                end
            end
            CPU_RD: begin
                cpu_rdata_d = bus.mem_rdata;
                state_d     = IDLE;
            end
            LD_RD: begin
                ld_rdata_d = bus.mem_rdata;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Loader starvation counter: saturates at STARVE_MAX, cleared by a grant or a dropped request.
    always_comb begin
        ld_wait_d = ld_wait_q;
        if (!bus.ld_req || ld_gnt_c)
            ld_wait_d = '0;
        else if (ld_wait_q < WAIT_W'(STARVE_MAX))
            ld_wait_d = ld_wait_q + WAIT_W'(1);
    end

    assign cpu_stall_c = bus.cpu_req && !((cpu_win_c && bus.cpu_we) || (state_q == CPU_RD));

    assign bus.cpu_stall = cpu_stall_c;
    assign bus.cpu_rdata = cpu_rdata_d;
    assign bus.ld_rdata  = ld_rdata_d;
    assign bus.ld_rvalid = (state_q == LD_RD);
    assign bus.ld_gnt    = ld_gnt_c;
    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;

`ifdef ARB_PERF_EN
    logic [15:0] perf_stall_cnt_q, perf_stall_cnt_d;

    always_comb begin
        perf_stall_cnt_d = perf_stall_cnt_q;
        if (cpu_stall_c && (perf_stall_cnt_q != 16'hFFFF))
            perf_stall_cnt_d = perf_stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) perf_stall_cnt_q <= '0;
        else        perf_stall_cnt_q <= perf_stall_cnt_d;
    end

    assign bus.perf_stall_cnt = perf_stall_cnt_q;
`else
    assign bus.perf_stall_cnt = 16'd0;
`endif
endmodule
